// File: rtl/down_counter_pkg.sv
// Shared types and constants for the loadable down counter.
// Holds the FSM state encoding and the default counter width.
package down_counter_pkg;

    localparam int unsigned DC_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dc_state_e;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with terminal-count pulse and auto-reload.
// Ports: clk, rst_n (async active-low), en, load, load_val[W],
//        auto_reload -> count[W], zero, tc (registered), busy.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    dc_state_e        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            // Load beats every other event, including terminal count.
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? RUN : DONE;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (en) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else begin
                            // Terminal step: never decrement past zero.
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = DONE;
                            end
                        end
                    end
                end
                IDLE, DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);
    assign tc    = tc_q;
    assign busy  = (state_q == RUN);

endmodule
